cordic_exp_scheduler: RTL and testbench
=======================================

# cordic_exp_scheduler

Round-robin scheduler that shares one pipelined 8-bit CORDIC exponential core (`CORDIC_Exponential_8bit`, fixed latency) between NREQ requesters. It accepts one angle per cycle via valid/ready handshakes and drives the core's angle, Xin and Yin inputs. Requester IDs travel down a latency-matched tag pipeline, so each result returns with the ID of the requester that issued it. A halt/drain FSM lets the system quiesce the core before reconfiguration or power-down.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- SZ, 8, angle/Xin/Yin width
- LAT, 8, core latency in cycles from the edge where the core samples cordic_angle to the cycle where cordic_exp is valid (≥1)
- XIN_INIT, 77, gain-compensated Xin constant (64/0.82815936, truncated)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_angle  in  NREQ*SZ  per-requester angle; requester i occupies bits [i*SZ +: SZ]
- req_ready  out  NREQ  one-hot grant; combinational
- halt  in  1  stop accepting requests and drain in-flight work
- idle  out  1  high when halted and fully drained
- cordic_angle  out  SZ  to core angle
- cordic_xin  out  SZ  to core Xin
- cordic_yin  out  SZ  to core Yin
- cordic_exp  in  SZ+2  from core exp
- res_valid  out  1  result strobe, one cycle per result
- res_id  out  clog2(NREQ)  requester ID of the result
- res_exp  out  SZ+2  result value

## Operation
- Arbitration: a round-robin pointer `last` holds the most recently granted index. Search order is last+1, last+2, … modulo NREQ. The first requester with req_valid=1 gets req_ready=1; all other ready bits are 0.
- req_ready depends combinationally on req_valid, halt, state and `last`. It is forced to 0 while halt=1 or rst_n=0.
- Accept = req_valid[i] & req_ready[i] at a rising edge. On an accept:
  - cordic_angle ← req_angle[i]
  - `last` ← i
  - a tag {valid=1, id=i} enters tag-pipeline stage 0.
- Cycles with no accept: cordic_angle holds its value. A tag {valid=0} enters the pipeline.
- cordic_xin is held at XIN_INIT; cordic_yin is held at 0. Neither ever changes.
- The tag pipeline has LAT stages. The tag emerging from the last stage is registered together with cordic_exp into res_valid/res_id/res_exp.
- In-flight counter: width clog2(LAT+3). It increments on accept and decrements on res_valid. When both happen in the same cycle, it is unchanged. It never wraps: at most LAT+1 items can be in flight.
- FSM states and transitions:
  - RUN: arbitration enabled. halt=1 → DRAIN.
  - DRAIN: no accepts. halt=0 → RUN. halt=1 and counter==0 → HALTED.
  - HALTED: idle=1, no accepts. halt=0 → RUN.
  - Transitions take effect at the next edge. Gating of req_ready by halt is immediate (same cycle).
- Results are never back-pressured. Requesters must consume res_valid cycles addressed to their ID.

## Timing
- Throughput: one accept per cycle, sustained, in RUN.
- Latency: accept at edge E → cordic_angle visible in cycle E..E+1 → core samples at edge E+1 → cordic_exp valid in cycle E+1+LAT → res_* registered at edge E+1+LAT. res_valid is therefore high in the cycle after edge E+LAT+1, a total of LAT+1 cycles after accept.
- Results emerge in accept order; no reordering.
- Reset values: cordic_angle=0, cordic_xin=XIN_INIT, cordic_yin=0, res_valid=0, res_id=0, res_exp=0, idle=0, state=RUN, last=NREQ-1 (requester 0 has first priority), counter=0, all tags invalid.
- Reset asserted mid-operation: in-flight items are discarded and no res_valid is produced for them. After release, the first accept is possible at the first edge.
- halt asserted in the same cycle as a req_valid: no accept.
- halt deasserted in DRAIN: RUN resumes at the next edge, and in-flight results still return normally.

## Test plan
- Single requester 0, angle swept 0x80..0x7F at one per cycle → 256 res_valid pulses. Each pulse has res_id=0, starts LAT+1 cycles after its accept, and res_exp matches the core's direct output for the same angle (in order).
- All 4 requesters valid continuously, angles 0x10+i → grants cycle 0,1,2,3,0,… and res_id follows the same sequence with no gaps.
- Requesters 1 and 3 valid, last=1 → requester 3 granted, then 1, then 3. Dropping req_valid[3] gives back-to-back grants to 1.
- Issue 5 requests, then assert halt → req_ready=0 immediately, state=DRAIN, all 5 results return, idle=1 exactly one cycle after the last res_valid. Deassert halt → idle=0 and accepts resume.
- Continuous traffic with accept and res_valid in the same cycle → counter stays at LAT+1 and never exceeds it.
- Pulse rst_n low with 3 items in flight → no res_valid for them, and all outputs return to their reset values asynchronously (before the next edge).

Source files
------------

// File: rtl/cordic_exp_scheduler.sv
// Round-robin front end sharing one pipelined CORDIC exponential core among NREQ requesters,
// with a latency-matched ID tag pipeline and a halt/drain FSM for quiescing the core.
module cordic_exp_scheduler #(
  parameter int NREQ     = 4,
  parameter int SZ       = 8,
  parameter int LAT      = 8,
  parameter int XIN_INIT = 77
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SZ-1:0]      req_angle,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    halt,
  output logic                    idle,
  output logic [SZ-1:0]           cordic_angle,
  output logic [SZ-1:0]           cordic_xin,
  output logic [SZ-1:0]           cordic_yin,
  input  logic [SZ+1:0]           cordic_exp,
  output logic                    res_valid,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [SZ+1:0]           res_exp
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(LAT + 3);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   grant_id;
  logic [IDW-1:0]   idx;
  logic             grant_any;
  logic             enable;
  logic             accept;
  logic [CW-1:0]    cnt;
  // Stage 0 runs alongside the cordic_angle register; stages 1..LAT track the core.
  logic [LAT:0]           tag_vld;
  logic [LAT:0][IDW-1:0]  tag_id;

  assign cordic_xin = SZ'(XIN_INIT);
  assign cordic_yin = '0;
  assign idle       = (state == HALTED);
  assign enable     = rst_n && !halt && (state == RUN);
  assign accept     = enable && grant_any;

  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (!grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready = NREQ'(1) << grant_id;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt) state_nxt = DRAIN;
      DRAIN:   if (!halt) state_nxt = RUN;
               else if (cnt == '0) state_nxt = HALTED;
      HALTED:  if (!halt) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      last         <= IDW'(NREQ - 1);
      cordic_angle <= '0;
      tag_vld      <= '0;
      tag_id       <= '0;
      res_valid    <= 1'b0;
      res_id       <= '0;
      res_exp      <= '0;
      cnt          <= '0;
    end else begin
      state   <= state_nxt;
      tag_vld <= {tag_vld[LAT-1:0], accept};
      tag_id  <= {tag_id[LAT-1:0], grant_id};
      if (accept) begin
        cordic_angle <= req_angle[grant_id*SZ +: SZ];
        last         <= grant_id;
      end
      res_valid <= tag_vld[LAT];
      res_id    <= tag_id[LAT];
      res_exp   <= cordic_exp;
      // An item retires on the edge that registers its result, so a full pipe holds LAT+1.
      case ({accept, tag_vld[LAT]})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_exp_scheduler.sv
// Bench for cordic_exp_scheduler: a behavioural core model, a request-level reference of
// arbitration/halt behaviour, and a scoreboard checking every result's ID, value and timing.
module tb_cordic_exp_scheduler;
  localparam int NREQ = 4;
  localparam int SZ   = 8;
  localparam int LAT  = 8;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*SZ-1:0]   req_angle = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 halt = 1'b0;
  logic                 idle;
  logic [SZ-1:0]        cordic_angle, cordic_xin, cordic_yin;
  logic [SZ+1:0]        cordic_exp;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [SZ+1:0]        res_exp;

  cordic_exp_scheduler #(.NREQ(NREQ), .SZ(SZ), .LAT(LAT), .XIN_INIT(77)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .halt(halt), .idle(idle), .cordic_angle(cordic_angle),
    .cordic_xin(cordic_xin), .cordic_yin(cordic_yin), .cordic_exp(cordic_exp),
    .res_valid(res_valid), .res_id(res_id), .res_exp(res_exp)
  );

  always #5 clk = ~clk;

  function automatic logic [SZ+1:0] core_fn(input logic [SZ-1:0] a);
    return ((SZ+2)'(a) * 10'd3) ^ 10'h155;
  endfunction

  // Stand-in for the CORDIC core: samples the angle each edge, result after LAT stages.
  logic [SZ+1:0] core_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    core_pipe[0] <= core_fn(cordic_angle);
    for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
  end
  assign cordic_exp = core_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [SZ+1:0] val; int due; } item_t;
  item_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int m_last = NREQ - 1;
  int m_state = 0;  // 0 running, 1 draining, 2 halted

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    item_t it;
    int gid, outstanding;
    logic [NREQ-1:0] exp_ready;
    if (!rst_n) begin
      q.delete();
      m_last  = NREQ - 1;
      m_state = 0;
    end else begin
      if (res_valid) begin
        if (q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          it = q.pop_front();
          check("res_id", res_id, it.id);
          check("res_exp", res_exp, it.val);
          check("res_cycle", cyc, it.due);
        end
      end
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missing_result_due", q[0].due, cyc);
        void'(q.pop_front());
      end
      exp_ready = '0;
      gid = -1;
      if (m_state == 0 && !halt)
        for (int k = 1; k <= NREQ; k++)
          if (gid < 0 && req_valid[(m_last + k) % NREQ]) gid = (m_last + k) % NREQ;
      if (gid >= 0) exp_ready[gid] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("idle", idle, m_state == 2);
      outstanding = q.size();
      if (gid >= 0) begin
        it.id  = gid;
        it.val = core_fn(req_angle[gid*SZ +: SZ]);
        it.due = cyc + LAT + 2;
        q.push_back(it);
        m_last = gid;
      end
      case (m_state)
        0: if (halt) m_state = 1;
        1: if (!halt) m_state = 0; else if (outstanding == 0) m_state = 2;
        default: if (!halt) m_state = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_res_exp"}, res_exp, 0);
    check({tag, "_angle"}, cordic_angle, 0);
    check({tag, "_idle"}, idle, 0);
    check({tag, "_ready"}, req_ready, 0);
    check({tag, "_xin"}, cordic_xin, 77);
    check({tag, "_yin"}, cordic_yin, 0);
  endtask

  initial begin
    logic [SZ-1:0] a;
    int k;
    req_valid = '1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single requester, full angle sweep at one per cycle.
    req_valid = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      a = 8'h80 + 8'(i);
      req_angle[0 +: SZ] = a;
      tick();
    end

    // All requesters continuously valid.
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_angle[i*SZ +: SZ] = 8'h10 + 8'(i);
    repeat (40) tick();

    // Requesters 1 and 3 with last=1, then only requester 1.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    repeat (3) tick();
    req_valid = 4'b0010;
    repeat (3) tick();

    // Random traffic with occasional halt pulses.
    for (int i = 0; i < 1500; i++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      req_angle = $urandom;
      halt = ($urandom_range(0, 19) == 0);
      tick();
    end

    // Five requests, then halt and drain.
    halt = 1'b0;
    req_valid = '0;
    repeat (3) tick();
    req_valid = 4'b0101;
    repeat (5) tick();
    halt = 1'b1;
    #1;
    check("halt_ready_gated", req_ready, 0);
    k = 0;
    while (!idle && k < 60) begin tick(); k++; end
    check("halt_drain_reached_idle", idle, 1);
    repeat (3) tick();
    halt = 1'b0;
    repeat (6) tick();

    // Asynchronous reset with three items in flight.
    req_valid = '0;
    repeat (LAT + 4) tick();
    req_valid = 4'b1000;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0011;
    req_angle = $urandom;
    repeat (10) tick();

    req_valid = '0;
    repeat (LAT + 4) tick();
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
